// File: rtl/fifo_push_arbiter_pkg.sv
// ============================================================================
// fifo_arb_pkg
// Shared constants, beat type and helpers for the FIFO push arbiter family.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  localparam int c_NUM_REQ_MIN = 2;
  localparam int c_NUM_REQ_MAX = 16;
  localparam int c_DATA_WIDTH  = 32;
  localparam int c_LAST_BIT    = c_DATA_WIDTH;

  // Default-width beat: payload plus end-of-packet flag in the top bit.
  typedef logic [c_LAST_BIT:0] beat_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit num_req_ok(input int n);
    return (n >= c_NUM_REQ_MIN) && (n <= c_NUM_REQ_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_push_arbiter_rr_pick.sv
// ============================================================================
// rr_pick
// Combinational rotate-priority picker: first set request at or after i_start.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // Scanned from the far end so the nearest candidate is written last and wins.
  always_comb begin
    logic [W:0] cand;
    o_idx = i_start;
    o_any = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, i_start} + (W+1)'(k);
      if (cand >= (W+1)'(N)) begin
        cand = cand - (W+1)'(N);
      end
      if (i_req[cand[W-1:0]]) begin
        o_idx = cand[W-1:0];
        o_any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
// ============================================================================
// fifo_push_arbiter
// Round-robin sharing of one FIFO push port among NUM_REQ producers.
// Optional packet lock: define FIFO_ARB_PKT_LOCK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = c_DATA_WIDTH,
  localparam int IDX_W      = idx_w(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH:0]   req_data_i,
  output logic [NUM_REQ-1:0]                 req_grant_o,
  output logic                               fifo_push_valid_o,
  output logic [DATA_WIDTH:0]                fifo_push_data_o,
  input  logic                               fifo_push_grant_i,
  output logic [IDX_W-1:0]                   owner_o,
  output logic                               locked_o
);

  if (!num_req_ok(NUM_REQ)) begin : g_num_req_check
    $error("fifo_push_arbiter: NUM_REQ out of range");
  end

  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_ptr_next;
  logic [IDX_W:0]   w_ptr_inc;
  logic             w_acc;
  logic             w_release;

  rr_pick #(
    .N (NUM_REQ),
    .W (IDX_W)
  ) u_pick (
    .i_req   (req_valid_i),
    .i_start (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

`ifdef FIFO_ARB_PKT_LOCK_EN
  logic             r_lock;
  logic [IDX_W-1:0] r_owner;

  // While locked, other producers' valids are ignored entirely.
  assign w_winner          = r_lock ? r_owner : w_pick_idx;
  assign fifo_push_valid_o = r_lock ? req_valid_i[r_owner] : w_pick_any;
  assign locked_o          = r_lock;
  assign w_release         = fifo_push_data_o[DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock  <= 1'b0;
      r_owner <= '0;
    end else if (w_acc) begin
      r_lock <= ~w_release;
      if (!w_release) begin
        r_owner <= w_winner;
      end
    end
  end
`else
  assign w_winner          = w_pick_idx;
  assign fifo_push_valid_o = w_pick_any;
  assign locked_o          = 1'b0;
  assign w_release         = 1'b1;
`endif

  assign fifo_push_data_o = req_data_i[w_winner];
  assign owner_o          = w_winner;
  assign w_acc            = fifo_push_valid_o & fifo_push_grant_i;
  assign req_grant_o      = w_acc ? (NUM_REQ'(1) << w_winner) : '0;

  // Explicit wrap so non-power-of-two NUM_REQ never yields an out-of-range index.
  assign w_ptr_inc  = {1'b0, w_winner} + (IDX_W+1)'(1);
  assign w_ptr_next = (w_ptr_inc >= (IDX_W+1)'(NUM_REQ)) ? '0 : w_ptr_inc[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_acc && w_release) begin
      r_rr_ptr <= w_ptr_next;
    end
  end

endmodule

`default_nettype wire
